// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs instruction fields into 32-bit words, tags each
// word with a sequential instruction-memory address and queues it in an output FIFO.
module instr_encoder #(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Clear,
    input  logic              InValid,
    output logic              InReady,
    input  logic [2:0]        InstType,
    input  logic [6:0]        OpCode,
    input  logic [2:0]        Funct3,
    input  logic [6:0]        Funct7,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Rs1,
    input  logic [4:0]        Rs2,
    input  logic [31:0]       Imm,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [31:0]       OutWord,
    output logic [ADDR_W-1:0] OutAddr,
    output logic              ErrFlag,
    output logic [7:0]        ErrCount
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;

    localparam logic [6:0] OP_IMM = 7'b0010011;

    // ------------------------------------------------------------------
    // Combinational encode and legality check
    // ------------------------------------------------------------------
    logic        is_shift;
    logic        sext12;
    logic        sext13;
    logic        sext21;
    logic [31:0] enc_word;
    logic        enc_legal;

    assign is_shift = (OpCode == OP_IMM) && ((Funct3 == 3'b001) || (Funct3 == 3'b101));
    assign sext12   = (Imm[31:11] == {21{Imm[11]}});
    assign sext13   = (Imm[31:12] == {20{Imm[12]}});
    assign sext21   = (Imm[31:20] == {12{Imm[20]}});

    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
        case (InstType)
            TYPE_R: begin
                enc_word  = {Funct7, Rs2, Rs1, Funct3, Rd, OpCode};
                enc_legal = 1'b1;
            end
            TYPE_I: begin
                if (is_shift) begin
                    // Shift immediates carry the shamt in [24:20] and funct7 above it.
                    enc_word  = {Funct7, Imm[4:0], Rs1, Funct3, Rd, OpCode};
                    enc_legal = (Imm[31:5] == 27'd0);
                end else begin
                    enc_word  = {Imm[11:0], Rs1, Funct3, Rd, OpCode};
                    enc_legal = sext12;
                end
            end
            TYPE_S: begin
                enc_word  = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], OpCode};
                enc_legal = sext12;
            end
            TYPE_B: begin
                enc_word  = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], OpCode};
                enc_legal = sext13 && !Imm[0];
            end
            TYPE_U: begin
                enc_word  = {Imm[31:12], Rd, OpCode};
                enc_legal = (Imm[11:0] == 12'd0);
            end
            TYPE_J: begin
                enc_word  = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, OpCode};
                enc_legal = sext21 && !Imm[0];
            end
            default: begin
                enc_word  = 32'd0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       out_word_q, out_word_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              err_flag_q, err_flag_d;
    logic [7:0]        err_count_q, err_count_d;

    logic accept;
    logic push;
    logic reject;
    logic pop;

    assign InReady  = (count_q != CNT_FULL);
    assign OutValid = (count_q != '0);
    assign OutWord  = out_word_q;
    assign OutAddr  = out_addr_q;
    assign ErrFlag  = err_flag_q;
    assign ErrCount = err_count_q;

    assign accept = InValid && InReady && !Clear;
    assign push   = accept && enc_legal;
    assign reject = accept && !enc_legal;
    assign pop    = OutValid && OutReady && !Clear;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]       mem_word [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr_q] <= enc_word;
            mem_addr[wr_ptr_q] <= addr_q;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_d      = addr_q;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        err_flag_d  = err_flag_q;
        err_count_d = err_count_q;

        if (Clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            addr_d   = BASE_ADDR;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                addr_d   = addr_q + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            if (reject) begin
                err_flag_d = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end

            // Head register reloads when the head moves; the word being pushed
            // this cycle becomes the head directly if nothing older remains.
            if ((pop || !OutValid) && (count_d != '0)) begin
                if (count_q == (pop ? CNT_ONE : '0)) begin
                    out_word_d = enc_word;
                    out_addr_d = addr_q;
                end else begin
                    out_word_d = mem_word[rd_ptr_d];
                    out_addr_d = mem_addr[rd_ptr_d];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= BASE_ADDR;
            out_word_q  <= 32'd0;
            out_addr_q  <= BASE_ADDR;
            err_flag_q  <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, rejections, backpressure, clear,
// asynchronous reset and address wrap on a narrow-address instance.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        Clear;
    logic        InValid;
    logic        OutReady;
    logic [2:0]  InstType;
    logic [6:0]  OpCode;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [4:0]  Rd;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [31:0] Imm;
    logic        InReady;
    logic        OutValid;
    logic [31:0] OutWord;
    logic [31:0] OutAddr;
    logic        ErrFlag;
    logic [7:0]  ErrCount;

    logic        Clear4;
    logic        InValid4;
    logic        OutReady4;
    logic        InReady4;
    logic        OutValid4;
    logic [31:0] OutWord4;
    logic [3:0]  OutAddr4;
    logic        ErrFlag4;
    logic [7:0]  ErrCount4;

    int errors = 0;
    int checks = 0;

    instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .Clear(Clear),
        .InValid(InValid), .InReady(InReady),
        .InstType(InstType), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
        .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Imm(Imm),
        .OutValid(OutValid), .OutReady(OutReady), .OutWord(OutWord), .OutAddr(OutAddr),
        .ErrFlag(ErrFlag), .ErrCount(ErrCount)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'h0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .Clear(Clear4),
        .InValid(InValid4), .InReady(InReady4),
        .InstType(InstType), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
        .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Imm(Imm),
        .OutValid(OutValid4), .OutReady(OutReady4), .OutWord(OutWord4), .OutAddr(OutAddr4),
        .ErrFlag(ErrFlag4), .ErrCount(ErrCount4)
    );

    // addi x1, x0, k
    function automatic logic [31:0] addi_word(input int k);
        return {12'(k), 5'd0, 3'd0, 5'd1, 7'b0010011};
    endfunction

    task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        InstType = t; OpCode = op; Funct3 = f3; Funct7 = f7;
        Rd = rd; Rs1 = rs1; Rs2 = rs2; Imm = imm;
    endtask

    task automatic set_addi(input int k);
        set_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(k));
    endtask

    task automatic send();
        InValid = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
    endtask

    task automatic pop_one();
        OutReady = 1'b1;
        @(posedge clk); #1;
        OutReady = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Clear = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        Clear4 = 1'b0; InValid4 = 1'b0; OutReady4 = 1'b0;
        set_req(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b expected 0", OutValid); end
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready: got %b expected 1", InReady); end
        checks++; if (OutWord !== 32'd0) begin errors++; $display("FAIL reset_outword: got %h expected 0", OutWord); end
        checks++; if (OutAddr !== 32'd0) begin errors++; $display("FAIL reset_outaddr: got %h expected 0", OutAddr); end
        checks++; if (ErrFlag !== 1'b0) begin errors++; $display("FAIL reset_errflag: got %b expected 0", ErrFlag); end
        checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL reset_errcount: got %0d expected 0", ErrCount); end
    endtask

    task automatic test_encode();
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin set_req(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0); exp = 32'h002081B3; end
                1: begin set_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF); exp = 32'hFFF00093; end
                2: begin set_req(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8); exp = 32'h00208463; end
                3: begin set_req(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800); exp = 32'h001000EF; end
                4: begin set_req(3'd1, 7'b0010011, 3'b101, 7'b0100000, 5'd5, 5'd5, 5'd0, 32'd3); exp = 32'h4032D293; end
                5: begin set_req(3'd2, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8); exp = 32'h0020A423; end
                6: begin set_req(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000); exp = 32'h123452B7; end
                default: begin set_req(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC); exp = 32'hFE000EE3; end
            endcase
            send();
            @(negedge clk);
            $display("enc %0d: word=%h addr=%h", i, OutWord, OutAddr);
            checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL enc_valid[%0d]: got %b expected 1", i, OutValid); end
            checks++; if (OutWord !== exp) begin errors++; $display("FAIL enc_word[%0d]: got %h expected %h", i, OutWord, exp); end
            checks++; if (OutAddr !== 32'(i * 4)) begin errors++; $display("FAIL enc_addr[%0d]: got %h expected %h", i, OutAddr, 32'(i * 4)); end
            pop_one();
            @(negedge clk);
            checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL enc_empty[%0d]: got %b expected 0", i, OutValid); end
        end
    endtask

    task automatic test_reject();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: set_req(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
                1: set_req(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00001001);
                2: set_req(3'd7, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
                3: set_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
                4: set_req(3'd1, 7'b0010011, 3'b001, 7'd0, 5'd1, 5'd1, 5'd0, 32'd32);
                default: set_req(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h1000);
            endcase
            send();
            @(negedge clk);
            $display("rej %0d: errflag=%b errcount=%0d", i, ErrFlag, ErrCount);
            checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rej_nopush[%0d]: got %b expected 0", i, OutValid); end
            checks++; if (ErrFlag !== 1'b1) begin errors++; $display("FAIL rej_flag[%0d]: got %b expected 1", i, ErrFlag); end
            checks++; if (ErrCount !== 8'(i + 1)) begin errors++; $display("FAIL rej_count[%0d]: got %0d expected %0d", i, ErrCount, i + 1); end
        end
        // Legal requests after the rejections use the unadvanced address.
        set_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
        send();
        @(negedge clk);
        checks++; if (OutWord !== 32'hFFF00093) begin errors++; $display("FAIL rej_next_word: got %h expected fff00093", OutWord); end
        checks++; if (OutAddr !== 32'h20) begin errors++; $display("FAIL rej_next_addr: got %h expected 00000020", OutAddr); end
        pop_one();
        set_req(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800);
        send();
        @(negedge clk);
        checks++; if (OutWord !== 32'h80000093) begin errors++; $display("FAIL imm_min_word: got %h expected 80000093", OutWord); end
        checks++; if (OutAddr !== 32'h24) begin errors++; $display("FAIL imm_min_addr: got %h expected 00000024", OutAddr); end
        pop_one();
    endtask

    task automatic test_backpressure();
        int  got;
        logic acc;
        Clear = 1'b1;
        @(posedge clk); #1;
        Clear = 1'b0;
        @(negedge clk);
        checks++; if (ErrFlag !== 1'b1) begin errors++; $display("FAIL clear_keeps_flag: got %b expected 1", ErrFlag); end
        checks++; if (ErrCount !== 8'd6) begin errors++; $display("FAIL clear_keeps_count: got %0d expected 6", ErrCount); end
        OutReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_addi(k);
            send();
        end
        @(negedge clk);
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL full_inready: got %b expected 0", InReady); end
        set_addi(4);
        InValid = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL full_hold: got %b expected 0", InReady); end
        checks++; if (OutWord !== addi_word(0)) begin errors++; $display("FAIL full_head: got %h expected %h", OutWord, addi_word(0)); end
        got = 0;
        OutReady = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            if (cyc == 0) begin
                checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL full_pop_inready: got %b expected 0", InReady); end
            end
            acc = InValid && InReady;
            if (OutValid) begin
                $display("drain %0d: word=%h addr=%h", got, OutWord, OutAddr);
                checks++; if (OutWord !== addi_word(got)) begin errors++; $display("FAIL drain_word[%0d]: got %h expected %h", got, OutWord, addi_word(got)); end
                checks++; if (OutAddr !== 32'(got * 4)) begin errors++; $display("FAIL drain_addr[%0d]: got %h expected %h", got, OutAddr, 32'(got * 4)); end
                got++;
            end
            @(posedge clk); #1;
            if (acc) InValid = 1'b0;
            @(negedge clk);
        end
        OutReady = 1'b0;
        InValid = 1'b0;
        checks++; if (got != 5) begin errors++; $display("FAIL drain_total: got %0d expected 5", got); end
    endtask

    task automatic test_back_to_back();
        int got;
        OutReady = 1'b0;
        set_addi(10); send();
        set_addi(11); send();
        set_addi(12);
        InValid = 1'b1; OutReady = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0; OutReady = 1'b0;
        @(negedge clk);
        checks++; if (OutWord !== addi_word(11)) begin errors++; $display("FAIL b2b_head_word: got %h expected %h", OutWord, addi_word(11)); end
        checks++; if (OutAddr !== 32'h18) begin errors++; $display("FAIL b2b_head_addr: got %h expected 00000018", OutAddr); end
        got = 0;
        OutReady = 1'b1;
        for (int cyc = 0; cyc < 10 && OutValid; cyc++) begin
            $display("b2b %0d: word=%h addr=%h", got, OutWord, OutAddr);
            checks++; if (OutWord !== addi_word(11 + got)) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", got, OutWord, addi_word(11 + got)); end
            got++;
            @(negedge clk);
        end
        OutReady = 1'b0;
        checks++; if (got != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got); end
    endtask

    task automatic test_clear();
        set_addi(20); send();
        set_addi(21);
        InValid = 1'b1; OutReady = 1'b1; Clear = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0; OutReady = 1'b0; Clear = 1'b0;
        @(negedge clk);
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL clear_empty: got %b expected 0", OutValid); end
        checks++; if (ErrFlag !== 1'b1) begin errors++; $display("FAIL clear_errflag: got %b expected 1", ErrFlag); end
        set_req(3'd7, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        InValid = 1'b1; Clear = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0; Clear = 1'b0;
        @(negedge clk);
        checks++; if (ErrCount !== 8'd6) begin errors++; $display("FAIL clear_no_err: got %0d expected 6", ErrCount); end
        set_addi(22); send();
        @(negedge clk);
        $display("clear: word=%h addr=%h", OutWord, OutAddr);
        checks++; if (OutAddr !== 32'h0) begin errors++; $display("FAIL clear_base_addr: got %h expected 00000000", OutAddr); end
        checks++; if (OutWord !== addi_word(22)) begin errors++; $display("FAIL clear_word: got %h expected %h", OutWord, addi_word(22)); end
        pop_one();
    endtask

    task automatic test_async_reset();
        OutReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_addi(40 + k);
            send();
        end
        @(negedge clk);
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL ar_queued: got %b expected 1", OutValid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL ar_outvalid: got %b expected 0", OutValid); end
        checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL ar_errcount: got %0d expected 0", ErrCount); end
        checks++; if (ErrFlag !== 1'b0) begin errors++; $display("FAIL ar_errflag: got %b expected 0", ErrFlag); end
        checks++; if (OutWord !== 32'd0) begin errors++; $display("FAIL ar_outword: got %h expected 0", OutWord); end
        @(negedge clk);
        rst_n = 1'b1;
        set_addi(50); send();
        @(negedge clk);
        $display("post-reset: word=%h addr=%h", OutWord, OutAddr);
        checks++; if (OutAddr !== 32'h0) begin errors++; $display("FAIL ar_base_addr: got %h expected 00000000", OutAddr); end
        checks++; if (OutWord !== addi_word(50)) begin errors++; $display("FAIL ar_word: got %h expected %h", OutWord, addi_word(50)); end
        pop_one();
    endtask

    task automatic test_wrap();
        logic [3:0] exp4;
        set_addi(7);
        for (int k = 0; k < 5; k++) begin
            exp4 = 4'(k * 4);
            InValid4 = 1'b1;
            @(posedge clk); #1;
            InValid4 = 1'b0;
            @(negedge clk);
            $display("wrap %0d: word=%h addr=%h", k, OutWord4, OutAddr4);
            checks++; if (OutValid4 !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d]: got %b expected 1", k, OutValid4); end
            checks++; if (OutAddr4 !== exp4) begin errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k, OutAddr4, exp4); end
            OutReady4 = 1'b1;
            @(posedge clk); #1;
            OutReady4 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_reject();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
